reorder_buffer: RTL and testbench
=================================

Name: reorder_buffer

Overview:
- In-order retirement buffer that drives the two architectural register-file write ports.
- Accepts up to 2 dispatched instructions per cycle and allocates them in program order.
- Takes up to 2 out-of-order writeback results per cycle, tagged by buffer index.
- Retires up to 2 completed head entries per cycle, in order, as regfile write-port transactions (port 1 = older, port 2 = younger).

Parameters:
- ROB_DEPTH, 16, number of entries; must be a power of two, at least 4.
- ROB_SEL, 4, log2(ROB_DEPTH); width of tags and of the head/tail pointers.
- ARF_SEL, `RV32_ARF_SEL (5), architectural register index width.
- DATA_WIDTH, `RV32_DATA_WIDTH (32), result data width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- i_flush  in  1  synchronous clear of all entries.
- i_dp_en_1 / i_dp_en_2  in  1 each  dispatch valid; slot 1 is older.
- i_dp_rd_1 / i_dp_rd_2  in  ARF_SEL each  destination register.
- i_dp_wr_1 / i_dp_wr_2  in  1 each  instruction writes a register.
- o_dp_tag_1 / o_dp_tag_2  out  ROB_SEL each  tag assigned to each dispatch slot.
- o_dp_ready  out  1  at least 2 entries free.
- i_wb_en_1 / i_wb_en_2  in  1 each  writeback valid.
- i_wb_tag_1 / i_wb_tag_2  in  ROB_SEL each  writeback tag.
- i_wb_data_1 / i_wb_data_2  in  DATA_WIDTH each  writeback result.
- o_wr_en_1 / o_wr_en_2  out  1 each  regfile write enable.
- o_wr_addr_1 / o_wr_addr_2  out  ARF_SEL each  regfile write address.
- o_wr_data_1 / o_wr_data_2  out  DATA_WIDTH each  regfile write data.
- o_commit_cnt  out  2  number of entries retiring this cycle (0..2).
- o_count  out  ROB_SEL+1  number of occupied entries.
- o_empty  out  1  o_count == 0.

Behaviour:
- Per-entry state: valid, done, wr, rd, data. Pointers: head, tail, count.
- Reset: all valid/done bits cleared; head = tail = count = 0.
- Reset outputs: o_wr_en_* = 0, o_commit_cnt = 0, o_count = 0, o_empty = 1, o_dp_ready = 1, o_dp_tag_1 = 0, o_dp_tag_2 = 1.
- Reset asserted mid-operation clears all state immediately; in-flight entries are lost and no further writes occur.
- Dispatch:
  - Allocation count = i_dp_en_1 + i_dp_en_2.
  - The first enabled slot receives tag tail; the second receives tail+1 (mod ROB_DEPTH).
  - o_dp_tag_1 = tail and o_dp_tag_2 = tail+1 combinationally. If only i_dp_en_2 is set, that slot takes tag tail and o_dp_tag_2 shows tail.
  - A new entry is written with valid=1, done=0. Tail advances by the allocation count at the edge.
- o_dp_ready = (ROB_DEPTH - count) >= 2, computed from registered count only; same-cycle commits are not credited.
- Dispatch while o_dp_ready = 0 is ignored entirely: no allocation, no pointer change.
- Writeback: sets done=1 and stores data at the tagged entry on the edge.
  - Writeback to an invalid entry is ignored.
  - If both ports target the same tag, port 2 data wins.
- Commit is combinational from registered state and retires strictly in order:
  - c1 = valid[head] & done[head].
  - c2 = c1 & valid[head+1] & done[head+1].
  - o_wr_en_1 = c1 & wr[head] & (rd[head] != 0), so writes to x0 are suppressed. Port 2 uses the same rule on head+1 gated by c2.
  - Entries with wr=0 still retire and count toward o_commit_cnt.
  - Retired entries are invalidated and head advances by o_commit_cnt at the edge.
- Both commit slots may target the same rd. Both enables are asserted and the regfile's port-2-wins rule gives correct program order.
- Count update: count_next = count + allocations - o_commit_cnt. Head and tail wrap modulo ROB_DEPTH; count distinguishes full from empty.
- A full buffer (count = ROB_DEPTH) can still commit. Dispatch stays blocked until count <= ROB_DEPTH-2 at a cycle start.
- Flush: the current cycle's commit outputs remain valid, because those entries are older. At the edge all entries are invalidated and head = tail = count = 0. Flush overrides dispatch and writeback in the same cycle.
- Latency:
  - A writeback at edge N makes the entry commit-eligible in the cycle after edge N.
  - The regfile write happens at edge N+1, provided the entry is at head.

Decomposition:
- Shared constants header: ROB_DEPTH, ROB_SEL, and the existing RV32_ARF_SEL / RV32_DATA_WIDTH.
- No sub-module. Entry storage is flat per-field arrays inside the block. Pointer increment with wrap is a local function.

Test Plan:
- Reset, dispatch 2 (rd=3, rd=4), writeback tag1 then tag0 with data 0xA, 0xB -> nothing commits until tag0 is done; the next cycle shows both commits with wr_en_1/2 = 1, addr 3/4, data 0xB/0xA, o_commit_cnt = 2.
- Fill with 16 dispatches -> o_count = 16 and o_dp_ready = 0 from count 15 onward; a further dispatch is ignored. Complete head -> one commit, count = 15, o_dp_ready still 0.
- Dispatch rd=0 with wr=1, then complete it -> o_commit_cnt = 1, o_wr_en_1 = 0.
- Two entries both rd=7, completed with 0x11 (older) and 0x22 -> both enables asserted in one cycle, addr_1 = addr_2 = 7, data_2 = 0x22.
- Run 40 dispatch/commit pairs to exercise pointer wrap -> tags cycle 0..15 correctly and o_count never exceeds 16.
- Assert i_flush with head complete and 3 entries pending -> that cycle commits the head; afterwards o_count = 0, o_empty = 1, o_dp_tag_1 = 0.

Source files
------------

// File: rtl/reorder_buffer_pkg.sv
// Sizing constants shared by the reorder buffer and the RV32 register file it retires into.
package reorder_buffer_pkg;
    localparam int RV32_ARF_SEL    = 5;
    localparam int RV32_DATA_WIDTH = 32;
    localparam int ROB_DEPTH       = 16;
    localparam int ROB_SEL         = $clog2(ROB_DEPTH);
endpackage

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: 2-wide dispatch, 2-wide tagged writeback, 2-wide in-order
// commit onto the two architectural register-file write ports (port 2 = younger).
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int ROB_DEPTH  = reorder_buffer_pkg::ROB_DEPTH,
    parameter int ROB_SEL    = reorder_buffer_pkg::ROB_SEL,
    parameter int ARF_SEL    = reorder_buffer_pkg::RV32_ARF_SEL,
    parameter int DATA_WIDTH = reorder_buffer_pkg::RV32_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_flush,
    input  logic                  i_dp_en_1,
    input  logic                  i_dp_en_2,
    input  logic [ARF_SEL-1:0]    i_dp_rd_1,
    input  logic [ARF_SEL-1:0]    i_dp_rd_2,
    input  logic                  i_dp_wr_1,
    input  logic                  i_dp_wr_2,
    output logic [ROB_SEL-1:0]    o_dp_tag_1,
    output logic [ROB_SEL-1:0]    o_dp_tag_2,
    output logic                  o_dp_ready,
    input  logic                  i_wb_en_1,
    input  logic                  i_wb_en_2,
    input  logic [ROB_SEL-1:0]    i_wb_tag_1,
    input  logic [ROB_SEL-1:0]    i_wb_tag_2,
    input  logic [DATA_WIDTH-1:0] i_wb_data_1,
    input  logic [DATA_WIDTH-1:0] i_wb_data_2,
    output logic                  o_wr_en_1,
    output logic                  o_wr_en_2,
    output logic [ARF_SEL-1:0]    o_wr_addr_1,
    output logic [ARF_SEL-1:0]    o_wr_addr_2,
    output logic [DATA_WIDTH-1:0] o_wr_data_1,
    output logic [DATA_WIDTH-1:0] o_wr_data_2,
    output logic [1:0]            o_commit_cnt,
    output logic [ROB_SEL:0]      o_count,
    output logic                  o_empty
);

    localparam logic [ROB_SEL:0] READY_MAX = (ROB_SEL+1)'(ROB_DEPTH - 2);

    logic [ROB_DEPTH-1:0]  r_valid;
    logic [ROB_DEPTH-1:0]  r_done;
    logic [ROB_DEPTH-1:0]  r_wr;
    logic [ARF_SEL-1:0]    r_rd   [ROB_DEPTH];
    logic [DATA_WIDTH-1:0] r_data [ROB_DEPTH];
    logic [ROB_SEL-1:0]    r_head;
    logic [ROB_SEL-1:0]    r_tail;
    logic [ROB_SEL:0]      r_count;

    logic [ROB_SEL-1:0]    w_head_1;
    logic [ROB_SEL-1:0]    w_tail_1;
    logic [ROB_SEL-1:0]    w_tag_2;
    logic                  w_dp_ready;
    logic                  w_alloc_1;
    logic                  w_alloc_2;
    logic [1:0]            w_alloc_cnt;
    logic                  w_c1;
    logic                  w_c2;
    logic [1:0]            w_commit_cnt;
    logic                  w_wb_ok_1;
    logic                  w_wb_ok_2;

    // Depth is a power of two, so wrap is plain truncation of the sum.
    function automatic logic [ROB_SEL-1:0] ptr_add(input logic [ROB_SEL-1:0] p, input logic [1:0] n);
        logic [ROB_SEL-1:0] w_n;
        w_n = ROB_SEL'(n);
        return p + w_n;
    endfunction

    // Dispatch handshake: slot k is accepted at the rising edge iff i_dp_en_k && o_dp_ready;
    // o_dp_ready looks only at the registered count, so same-cycle commits give no credit.
    assign w_dp_ready  = (r_count <= READY_MAX);
    assign w_alloc_1   = i_dp_en_1 & w_dp_ready;
    assign w_alloc_2   = i_dp_en_2 & w_dp_ready;
    assign w_alloc_cnt = {1'b0, w_alloc_1} + {1'b0, w_alloc_2};
    assign w_head_1    = ptr_add(r_head, 2'd1);
    assign w_tail_1    = ptr_add(r_tail, 2'd1);
    assign w_tag_2     = (i_dp_en_2 & ~i_dp_en_1) ? r_tail : w_tail_1;

    assign w_c1         = r_valid[r_head] & r_done[r_head];
    assign w_c2         = w_c1 & r_valid[w_head_1] & r_done[w_head_1];
    assign w_commit_cnt = {1'b0, w_c1} + {1'b0, w_c2};
    assign w_wb_ok_1    = i_wb_en_1 & r_valid[i_wb_tag_1];
    assign w_wb_ok_2    = i_wb_en_2 & r_valid[i_wb_tag_2];

    assign o_dp_tag_1   = r_tail;
    assign o_dp_tag_2   = w_tag_2;
    assign o_dp_ready   = w_dp_ready;
    assign o_wr_en_1    = w_c1 & r_wr[r_head] & (r_rd[r_head] != '0);
    assign o_wr_en_2    = w_c2 & r_wr[w_head_1] & (r_rd[w_head_1] != '0);
    assign o_wr_addr_1  = r_rd[r_head];
    assign o_wr_addr_2  = r_rd[w_head_1];
    assign o_wr_data_1  = r_data[r_head];
    assign o_wr_data_2  = r_data[w_head_1];
    assign o_commit_cnt = w_commit_cnt;
    assign o_count      = r_count;
    assign o_empty      = (r_count == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
            r_done  <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_valid <= '0;
            r_done  <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_wb_ok_1) r_done[i_wb_tag_1] <= 1'b1;
            if (w_wb_ok_2) r_done[i_wb_tag_2] <= 1'b1;
            if (w_c1) r_valid[r_head]   <= 1'b0;
            if (w_c2) r_valid[w_head_1] <= 1'b0;
            if (w_alloc_1) begin
                r_valid[r_tail] <= 1'b1;
                r_done[r_tail]  <= 1'b0;
            end
            if (w_alloc_2) begin
                r_valid[w_tag_2] <= 1'b1;
                r_done[w_tag_2]  <= 1'b0;
            end
            r_head  <= ptr_add(r_head, w_commit_cnt);
            r_tail  <= ptr_add(r_tail, w_alloc_cnt);
            r_count <= r_count + (ROB_SEL+1)'(w_alloc_cnt) - (ROB_SEL+1)'(w_commit_cnt);
        end
    end

    // Payload fields carry no reset: they are only observed behind a valid/done bit.
    always_ff @(posedge clk) begin
        if (!i_flush) begin
            if (w_alloc_1) begin
                r_wr[r_tail] <= i_dp_wr_1;
                r_rd[r_tail] <= i_dp_rd_1;
            end
            if (w_alloc_2) begin
                r_wr[w_tag_2] <= i_dp_wr_2;
                r_rd[w_tag_2] <= i_dp_rd_2;
            end
            if (w_wb_ok_1) r_data[i_wb_tag_1] <= i_wb_data_1;
            if (w_wb_ok_2) r_data[i_wb_tag_2] <= i_wb_data_2;
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed scenarios plus random traffic against a queue-based
// program-order model of the buffer.
module tb_reorder_buffer;
    import reorder_buffer_pkg::*;

    localparam int D  = 16;
    localparam int TW = 4;
    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          i_flush = 1'b0;
    logic          i_dp_en_1 = 1'b0, i_dp_en_2 = 1'b0;
    logic [AW-1:0] i_dp_rd_1 = '0, i_dp_rd_2 = '0;
    logic          i_dp_wr_1 = 1'b0, i_dp_wr_2 = 1'b0;
    logic [TW-1:0] o_dp_tag_1, o_dp_tag_2;
    logic          o_dp_ready;
    logic          i_wb_en_1 = 1'b0, i_wb_en_2 = 1'b0;
    logic [TW-1:0] i_wb_tag_1 = '0, i_wb_tag_2 = '0;
    logic [DW-1:0] i_wb_data_1 = '0, i_wb_data_2 = '0;
    logic          o_wr_en_1, o_wr_en_2;
    logic [AW-1:0] o_wr_addr_1, o_wr_addr_2;
    logic [DW-1:0] o_wr_data_1, o_wr_data_2;
    logic [1:0]    o_commit_cnt;
    logic [TW:0]   o_count;
    logic          o_empty;

    reorder_buffer dut (
        .clk(clk), .rst(rst), .i_flush(i_flush),
        .i_dp_en_1(i_dp_en_1), .i_dp_en_2(i_dp_en_2),
        .i_dp_rd_1(i_dp_rd_1), .i_dp_rd_2(i_dp_rd_2),
        .i_dp_wr_1(i_dp_wr_1), .i_dp_wr_2(i_dp_wr_2),
        .o_dp_tag_1(o_dp_tag_1), .o_dp_tag_2(o_dp_tag_2), .o_dp_ready(o_dp_ready),
        .i_wb_en_1(i_wb_en_1), .i_wb_en_2(i_wb_en_2),
        .i_wb_tag_1(i_wb_tag_1), .i_wb_tag_2(i_wb_tag_2),
        .i_wb_data_1(i_wb_data_1), .i_wb_data_2(i_wb_data_2),
        .o_wr_en_1(o_wr_en_1), .o_wr_en_2(o_wr_en_2),
        .o_wr_addr_1(o_wr_addr_1), .o_wr_addr_2(o_wr_addr_2),
        .o_wr_data_1(o_wr_data_1), .o_wr_data_2(o_wr_data_2),
        .o_commit_cnt(o_commit_cnt), .o_count(o_count), .o_empty(o_empty)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    // ---------------- reference model: program-order queue ----------------
    typedef struct {
        int            tag;
        int            rd;
        bit            wr;
        bit            done;
        logic [DW-1:0] data;
    } ent_t;

    ent_t m_q[$];
    int   m_tail;
    int   n_total = 0;
    int   n_bad   = 0;

    bit            e_ready, e_c1, e_c2, e_en1, e_en2;
    logic [TW-1:0] e_tag1, e_tag2;
    logic [1:0]    e_cnt;
    logic [TW:0]   e_count;
    logic [AW-1:0] e_rd1, e_rd2;
    logic [DW-1:0] e_d1, e_d2;

    task automatic predict();
        int n;
        n       = m_q.size();
        e_ready = (D - n) >= 2;
        e_count = (TW+1)'(n);
        e_tag1  = TW'(m_tail);
        e_tag2  = (i_dp_en_2 && !i_dp_en_1) ? TW'(m_tail) : TW'((m_tail + 1) % D);
        e_c1 = 1'b0; e_c2 = 1'b0; e_en1 = 1'b0; e_en2 = 1'b0;
        e_rd1 = '0; e_rd2 = '0; e_d1 = '0; e_d2 = '0;
        if (n >= 1) e_c1 = m_q[0].done;
        if (n >= 2) e_c2 = e_c1 && m_q[1].done;
        e_cnt = 2'(int'(e_c1) + int'(e_c2));
        if (e_c1) begin
            e_en1 = m_q[0].wr && (m_q[0].rd != 0);
            e_rd1 = AW'(m_q[0].rd);
            e_d1  = m_q[0].data;
        end
        if (e_c2) begin
            e_en2 = m_q[1].wr && (m_q[1].rd != 0);
            e_rd2 = AW'(m_q[1].rd);
            e_d2  = m_q[1].data;
        end
    endtask

    task automatic model_step();
        predict();
        if (i_flush) begin
            m_q.delete();
            m_tail = 0;
            return;
        end
        if (i_wb_en_1)
            foreach (m_q[k]) if (m_q[k].tag == int'(i_wb_tag_1)) begin
                m_q[k].done = 1'b1; m_q[k].data = i_wb_data_1;
            end
        if (i_wb_en_2)
            foreach (m_q[k]) if (m_q[k].tag == int'(i_wb_tag_2)) begin
                m_q[k].done = 1'b1; m_q[k].data = i_wb_data_2;
            end
        repeat (int'(e_cnt)) void'(m_q.pop_front());
        if (e_ready) begin
            if (i_dp_en_1) begin
                m_q.push_back('{tag: m_tail, rd: int'(i_dp_rd_1), wr: i_dp_wr_1, done: 1'b0, data: '0});
                m_tail = (m_tail + 1) % D;
            end
            if (i_dp_en_2) begin
                m_q.push_back('{tag: m_tail, rd: int'(i_dp_rd_2), wr: i_dp_wr_2, done: 1'b0, data: '0});
                m_tail = (m_tail + 1) % D;
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        i_dp_en_1 = 1'b0; i_dp_en_2 = 1'b0;
        i_wb_en_1 = 1'b0; i_wb_en_2 = 1'b0;
        i_flush   = 1'b0;
    endtask

    task automatic settle();
        #1;
        predict();
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic dispatch(input bit en1, input int rd1, input bit en2, input int rd2);
        i_dp_en_1 = en1; i_dp_rd_1 = AW'(rd1); i_dp_wr_1 = 1'b1;
        i_dp_en_2 = en2; i_dp_rd_2 = AW'(rd2); i_dp_wr_2 = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle_inputs();
        #1 rst = 1'b1;
        #1;
        n_total++;
        if ({o_wr_en_1, o_wr_en_2, o_commit_cnt} !== 4'b0000) begin
            n_bad++; $display("FAIL reset_commit got en=%b%b cnt=%0d want 00/0", o_wr_en_1, o_wr_en_2, o_commit_cnt);
        end
        n_total++;
        if (o_count !== 5'd0 || o_empty !== 1'b1) begin
            n_bad++; $display("FAIL reset_count got count=%0d empty=%b want 0/1", o_count, o_empty);
        end
        n_total++;
        if (o_dp_ready !== 1'b1) begin
            n_bad++; $display("FAIL reset_ready got %b want 1", o_dp_ready);
        end
        n_total++;
        if (o_dp_tag_1 !== 4'd0 || o_dp_tag_2 !== 4'd1) begin
            n_bad++; $display("FAIL reset_tags got %0d/%0d want 0/1", o_dp_tag_1, o_dp_tag_2);
        end
        @(negedge clk);
        rst = 1'b0;
        m_q.delete();
        m_tail = 0;
    endtask

    task automatic test_out_of_order();
        dispatch(1, 3, 1, 4);
        settle();
        n_total++;
        if (o_dp_tag_1 !== 4'd0 || o_dp_tag_2 !== 4'd1) begin
            n_bad++; $display("FAIL ooo_tags got %0d/%0d want 0/1", o_dp_tag_1, o_dp_tag_2);
        end
        tick();
        i_wb_en_1 = 1'b1; i_wb_tag_1 = 4'd1; i_wb_data_1 = 32'hA;
        settle();
        tick();
        i_wb_en_1 = 1'b1; i_wb_tag_1 = 4'd0; i_wb_data_1 = 32'hB;
        settle();
        n_total++;
        if (o_commit_cnt !== 2'd0) begin
            n_bad++; $display("FAIL ooo_wait got cnt=%0d want 0", o_commit_cnt);
        end
        tick();
        settle();
        n_total++;
        if ({o_commit_cnt, o_wr_en_1, o_wr_en_2, o_wr_addr_1, o_wr_addr_2} !== {2'd2, 1'b1, 1'b1, 5'd3, 5'd4}) begin
            n_bad++; $display("FAIL ooo_commit got cnt=%0d en=%b%b addr=%0d/%0d want 2 11 3/4",
                              o_commit_cnt, o_wr_en_1, o_wr_en_2, o_wr_addr_1, o_wr_addr_2);
        end
        n_total++;
        if (o_wr_data_1 !== 32'hB || o_wr_data_2 !== 32'hA) begin
            n_bad++; $display("FAIL ooo_data got %h/%h want b/a", o_wr_data_1, o_wr_data_2);
        end
        tick();
        settle();
        n_total++;
        if (o_empty !== 1'b1) begin
            n_bad++; $display("FAIL ooo_empty got %b want 1", o_empty);
        end
    endtask

    task automatic test_full();
        for (int k = 0; k < 8; k++) begin
            dispatch(1, $urandom_range(1, 31), 1, $urandom_range(1, 31));
            settle();
            n_total++;
            if (o_count !== e_count || o_dp_ready !== e_ready || o_dp_tag_1 !== e_tag1) begin
                n_bad++; $display("FAIL full_fill got count=%0d rdy=%b tag=%0d want %0d/%b/%0d",
                                  o_count, o_dp_ready, o_dp_tag_1, e_count, e_ready, e_tag1);
            end
            tick();
        end
        dispatch(1, 9, 0, 0);
        settle();
        n_total++;
        if (o_count !== 5'd16 || o_dp_ready !== 1'b0) begin
            n_bad++; $display("FAIL full_state got count=%0d rdy=%b want 16/0", o_count, o_dp_ready);
        end
        tick();
        settle();
        n_total++;
        if (o_count !== 5'd16 || o_dp_tag_1 !== e_tag1) begin
            n_bad++; $display("FAIL full_ignore got count=%0d tag=%0d want 16/%0d", o_count, o_dp_tag_1, e_tag1);
        end
        i_wb_en_1 = 1'b1; i_wb_tag_1 = TW'(m_q[0].tag); i_wb_data_1 = $urandom;
        tick();
        settle();
        n_total++;
        if (o_commit_cnt !== 2'd1) begin
            n_bad++; $display("FAIL full_commit got cnt=%0d want 1", o_commit_cnt);
        end
        tick();
        dispatch(1, 5, 0, 0);
        settle();
        n_total++;
        if (o_count !== 5'd15 || o_dp_ready !== 1'b0) begin
            n_bad++; $display("FAIL full_15 got count=%0d rdy=%b want 15/0", o_count, o_dp_ready);
        end
        tick();
        settle();
        n_total++;
        if (o_count !== 5'd15) begin
            n_bad++; $display("FAIL full_15_ignore got count=%0d want 15", o_count);
        end
        i_flush = 1'b1;
        tick();
    endtask

    task automatic test_x0();
        int t;
        t = m_tail;
        dispatch(1, 0, 0, 0);
        tick();
        i_wb_en_1 = 1'b1; i_wb_tag_1 = TW'(t); i_wb_data_1 = 32'h55;
        tick();
        settle();
        n_total++;
        if (o_commit_cnt !== 2'd1 || o_wr_en_1 !== 1'b0) begin
            n_bad++; $display("FAIL x0_suppress got cnt=%0d en1=%b want 1/0", o_commit_cnt, o_wr_en_1);
        end
        tick();
    endtask

    task automatic test_same_rd();
        int t;
        t = m_tail;
        dispatch(1, 7, 1, 7);
        tick();
        i_wb_en_1 = 1'b1; i_wb_tag_1 = TW'(t);           i_wb_data_1 = 32'h11;
        i_wb_en_2 = 1'b1; i_wb_tag_2 = TW'((t + 1) % D); i_wb_data_2 = 32'h22;
        tick();
        settle();
        n_total++;
        if ({o_wr_en_1, o_wr_en_2, o_wr_addr_1, o_wr_addr_2} !== {1'b1, 1'b1, 5'd7, 5'd7}
            || o_wr_data_1 !== 32'h11 || o_wr_data_2 !== 32'h22) begin
            n_bad++; $display("FAIL same_rd got en=%b%b addr=%0d/%0d data=%h/%h want 11 7/7 11/22",
                              o_wr_en_1, o_wr_en_2, o_wr_addr_1, o_wr_addr_2, o_wr_data_1, o_wr_data_2);
        end
        tick();
    endtask

    task automatic test_wb_collide();
        int t;
        t = m_tail;
        dispatch(1, 12, 0, 0);
        tick();
        i_wb_en_1 = 1'b1; i_wb_tag_1 = TW'(t); i_wb_data_1 = 32'h33;
        i_wb_en_2 = 1'b1; i_wb_tag_2 = TW'(t); i_wb_data_2 = 32'h44;
        tick();
        settle();
        n_total++;
        if (o_commit_cnt !== 2'd1 || o_wr_data_1 !== 32'h44) begin
            n_bad++; $display("FAIL wb_collide got cnt=%0d data=%h want 1/44", o_commit_cnt, o_wr_data_1);
        end
        tick();
    endtask

    task automatic test_wrap();
        int s;
        logic [DW-1:0] v;
        int rd;
        s = m_tail;
        for (int k = 0; k < 40; k++) begin
            rd = $urandom_range(1, 31);
            v  = $urandom;
            dispatch(1, rd, 0, 0);
            settle();
            n_total++;
            if (o_dp_tag_1 !== TW'((s + k) % D)) begin
                n_bad++; $display("FAIL wrap_tag k=%0d got %0d want %0d", k, o_dp_tag_1, (s + k) % D);
            end
            tick();
            i_wb_en_1 = 1'b1; i_wb_tag_1 = TW'((s + k) % D); i_wb_data_1 = v;
            tick();
            settle();
            n_total++;
            if (o_commit_cnt !== 2'd1 || o_wr_en_1 !== 1'b1 || o_wr_addr_1 !== AW'(rd)
                || o_wr_data_1 !== v || o_count > 5'd16) begin
                n_bad++; $display("FAIL wrap_commit k=%0d got cnt=%0d en=%b addr=%0d data=%h count=%0d want 1/1/%0d/%h",
                                  k, o_commit_cnt, o_wr_en_1, o_wr_addr_1, o_wr_data_1, o_count, rd, v);
            end
            tick();
        end
    endtask

    task automatic test_flush();
        int t;
        t = m_tail;
        dispatch(1, 21, 1, 22);
        tick();
        dispatch(1, 23, 1, 24);
        tick();
        i_wb_en_1 = 1'b1; i_wb_tag_1 = TW'(t); i_wb_data_1 = 32'hF00D;
        tick();
        i_flush = 1'b1;
        dispatch(1, 25, 0, 0);
        i_wb_en_1 = 1'b1; i_wb_tag_1 = TW'((t + 1) % D); i_wb_data_1 = 32'h1;
        settle();
        n_total++;
        if (o_commit_cnt !== 2'd1 || o_wr_en_1 !== 1'b1 || o_wr_addr_1 !== 5'd21 || o_wr_data_1 !== 32'hF00D) begin
            n_bad++; $display("FAIL flush_commit got cnt=%0d en=%b addr=%0d data=%h want 1/1/21/f00d",
                              o_commit_cnt, o_wr_en_1, o_wr_addr_1, o_wr_data_1);
        end
        tick();
        settle();
        n_total++;
        if (o_count !== 5'd0 || o_empty !== 1'b1 || o_dp_tag_1 !== 4'd0) begin
            n_bad++; $display("FAIL flush_clear got count=%0d empty=%b tag=%0d want 0/1/0", o_count, o_empty, o_dp_tag_1);
        end
    endtask

    task automatic test_reset_mid();
        dispatch(1, 2, 1, 3);
        tick();
        i_wb_en_1 = 1'b1; i_wb_tag_1 = 4'd0; i_wb_data_1 = 32'h7;
        i_wb_en_2 = 1'b1; i_wb_tag_2 = 4'd1; i_wb_data_2 = 32'h8;
        tick();
        #2 rst = 1'b1;
        #1;
        n_total++;
        if (o_count !== 5'd0 || {o_wr_en_1, o_wr_en_2, o_commit_cnt} !== 4'b0000) begin
            n_bad++; $display("FAIL reset_mid got count=%0d en=%b%b cnt=%0d want 0 00 0",
                              o_count, o_wr_en_1, o_wr_en_2, o_commit_cnt);
        end
        m_q.delete();
        m_tail = 0;
        @(negedge clk);
        rst = 1'b0;
        tick();
        settle();
        n_total++;
        if (o_empty !== 1'b1 || o_wr_en_1 !== 1'b0 || o_dp_tag_1 !== 4'd0) begin
            n_bad++; $display("FAIL reset_mid_after got empty=%b en1=%b tag=%0d want 1/0/0", o_empty, o_wr_en_1, o_dp_tag_1);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            i_dp_en_1 = ($urandom_range(0, 2) != 0);
            i_dp_en_2 = ($urandom_range(0, 2) == 0);
            i_dp_rd_1 = AW'($urandom_range(0, 31)); i_dp_wr_1 = ($urandom_range(0, 3) != 0);
            i_dp_rd_2 = AW'($urandom_range(0, 31)); i_dp_wr_2 = ($urandom_range(0, 3) != 0);
            i_wb_en_1 = ($urandom_range(0, 3) != 0);
            i_wb_en_2 = ($urandom_range(0, 1) != 0);
            if (m_q.size() > 0 && $urandom_range(0, 7) != 0) i_wb_tag_1 = TW'(m_q[$urandom_range(0, m_q.size() - 1)].tag);
            else i_wb_tag_1 = TW'($urandom_range(0, D - 1));
            if (m_q.size() > 0 && $urandom_range(0, 7) != 0) i_wb_tag_2 = TW'(m_q[$urandom_range(0, m_q.size() - 1)].tag);
            else i_wb_tag_2 = TW'($urandom_range(0, D - 1));
            i_wb_data_1 = $urandom;
            i_wb_data_2 = $urandom;
            i_flush     = ($urandom_range(0, 59) == 0);
            settle();
            n_total++;
            if (o_count !== e_count || o_empty !== (e_count == 0) || o_dp_ready !== e_ready) begin
                n_bad++; $display("FAIL rnd_occupancy c=%0d got count=%0d empty=%b rdy=%b want %0d/%b/%b",
                                  c, o_count, o_empty, o_dp_ready, e_count, (e_count == 0), e_ready);
            end
            n_total++;
            if (o_dp_tag_1 !== e_tag1 || o_dp_tag_2 !== e_tag2) begin
                n_bad++; $display("FAIL rnd_tags c=%0d got %0d/%0d want %0d/%0d", c, o_dp_tag_1, o_dp_tag_2, e_tag1, e_tag2);
            end
            n_total++;
            if (o_commit_cnt !== e_cnt || o_wr_en_1 !== e_en1 || o_wr_en_2 !== e_en2) begin
                n_bad++; $display("FAIL rnd_commit c=%0d got cnt=%0d en=%b%b want %0d %b%b",
                                  c, o_commit_cnt, o_wr_en_1, o_wr_en_2, e_cnt, e_en1, e_en2);
            end
            if (e_en1) begin
                n_total++;
                if (o_wr_addr_1 !== e_rd1 || o_wr_data_1 !== e_d1) begin
                    n_bad++; $display("FAIL rnd_port1 c=%0d got %0d:%h want %0d:%h", c, o_wr_addr_1, o_wr_data_1, e_rd1, e_d1);
                end
            end
            if (e_en2) begin
                n_total++;
                if (o_wr_addr_2 !== e_rd2 || o_wr_data_2 !== e_d2) begin
                    n_bad++; $display("FAIL rnd_port2 c=%0d got %0d:%h want %0d:%h", c, o_wr_addr_2, o_wr_data_2, e_rd2, e_d2);
                end
            end
            tick();
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_out_of_order();
        test_full();
        test_x0();
        test_same_rd();
        test_wb_collide();
        test_wrap();
        test_flush();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
